hs_npu_axi_mem_port: RTL

- Memory-side adapter directly downstream of the NPU memory ordering stage.
- Converts the ordering stage's word-burst read/write requests into AXI4 master transactions, one outstanding transaction at a time.
- Returns read bursts to the ordering stage as single-cycle data-valid pulses and accepts write bursts with a ready handshake.
- Sits between the ordering stage and the SoC interconnect.

---
 rtl/hs_npu_pkg.sv | 25 ++
 rtl/hs_npu_axi_beat_counter.sv | 29 ++
 rtl/hs_npu_axi_mem_port.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hs_npu_pkg.sv
// Shared NPU definitions: AXI response codes, fixed AXI burst attributes and
// the memory-port state encoding.
package hs_npu_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    RD_DONE,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } mp_state_e;

endpackage

// File: rtl/hs_npu_axi_beat_counter.sv
// Beat counter for one AXI data channel.
//   clr  : return to beat 0 (held while the port is idle)
//   inc  : a beat was accepted this cycle
//   cnt  : index of the beat currently expected
//   last : cnt is the final beat of a WORDS-beat burst
// The counter wraps after the final beat, so an over-long burst keeps
// indexing inside the burst buffer instead of running off its end.
module hs_npu_axi_beat_counter #(
  parameter int unsigned WORDS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] cnt,
  output logic       last
);

  localparam logic [3:0] LAST_IDX = 4'(WORDS - 1);

  assign last = (cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= 4'd0;
    else if (clr)    cnt <= 4'd0;
    else if (inc)    cnt <= last ? 4'd0 : cnt + 4'd1;
  end

endmodule

// File: rtl/hs_npu_axi_mem_port.sv
// NPU memory port: turns ordering-stage word-burst requests into AXI4 INCR
// bursts, one transaction in flight at a time.
//   req_*            : request from the ordering stage (sampled only in IDLE)
//   wr_data_i        : write burst, word 0 at the lowest address
//   rd_data_o/rd_valid_o : completed read burst, rd_valid_o is a 1-cycle pulse
//   wr_ready_o       : port is idle and will take a write this cycle
//   err_o            : sticky, any non-OKAY RRESP/BRESP or RLAST misplacement
//   m_ar*/m_r*/m_aw*/m_w*/m_b* : AXI4 master channels
module hs_npu_axi_mem_port
  import hs_npu_pkg::*;
#(
  parameter int unsigned BURST_WORDS = 2,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_read_i,
  input  logic                              req_write_i,
  input  logic                              req_invalidate_i,
  input  logic [ADDR_WIDTH-1:0]             req_address_i,
  input  logic [BURST_WORDS-1:0][31:0]      wr_data_i,
  output logic [BURST_WORDS-1:0][31:0]      rd_data_o,
  output logic                              rd_valid_o,
  output logic                              wr_ready_o,
  output logic                              err_o,
  output logic [ADDR_WIDTH-1:0]             m_araddr,
  output logic [7:0]                        m_arlen,
  output logic [2:0]                        m_arsize,
  output logic [1:0]                        m_arburst,
  output logic                              m_arvalid,
  input  logic                              m_arready,
  input  logic [31:0]                       m_rdata,
  input  logic [1:0]                        m_rresp,
  input  logic                              m_rlast,
  input  logic                              m_rvalid,
  output logic                              m_rready,
  output logic [ADDR_WIDTH-1:0]             m_awaddr,
  output logic [7:0]                        m_awlen,
  output logic [2:0]                        m_awsize,
  output logic [1:0]                        m_awburst,
  output logic                              m_awvalid,
  input  logic                              m_awready,
  output logic [31:0]                       m_wdata,
  output logic [3:0]                        m_wstrb,
  output logic                              m_wlast,
  output logic                              m_wvalid,
  input  logic                              m_wready,
  input  logic [1:0]                        m_bresp,
  input  logic                              m_bvalid,
  output logic                              m_bready
);

  mp_state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [BURST_WORDS-1:0][31:0] wdata_q;
  logic                        drop_q;    // current read result is to be discarded
  logic                        w_done_q;  // all W beats accepted (W may finish before AW)
  logic [3:0]                  r_cnt, w_cnt;
  logic                        r_last, w_last;
  logic                        r_hs, w_hs, rd_state;

  assign r_hs     = m_rvalid && m_rready;
  assign w_hs     = m_wvalid && m_wready;
  assign rd_state = (state_q == RD_ADDR) || (state_q == RD_DATA) || (state_q == RD_DONE);

  // Fixed burst attributes; address comes straight from the captured request.
  assign m_araddr  = addr_q;
  assign m_awaddr  = addr_q;
  assign m_arlen   = 8'(BURST_WORDS - 1);
  assign m_awlen   = 8'(BURST_WORDS - 1);
  assign m_arsize  = AXI_SIZE_4B;
  assign m_awsize  = AXI_SIZE_4B;
  assign m_arburst = AXI_BURST_INCR;
  assign m_awburst = AXI_BURST_INCR;
  assign m_wstrb   = 4'hF;

  hs_npu_axi_beat_counter #(.WORDS(BURST_WORDS)) u_r_cnt (
    .clk(clk), .rst_n(rst_n), .clr(state_q == IDLE), .inc(r_hs), .cnt(r_cnt), .last(r_last)
  );

  hs_npu_axi_beat_counter #(.WORDS(BURST_WORDS)) u_w_cnt (
    .clk(clk), .rst_n(rst_n), .clr(state_q == IDLE), .inc(w_hs), .cnt(w_cnt), .last(w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    rd_valid_o = 1'b0;
    // gated by rst_n so the ready reads 0 while reset is held
    wr_ready_o = (state_q == IDLE) && rst_n;
    m_wlast    = w_last;
    m_wdata    = '0;
    for (int i = 0; i < int'(BURST_WORDS); i++)
      if (w_cnt == 4'(i)) m_wdata = wdata_q[i];
    case (state_q)
      IDLE: begin
        if (req_write_i)                           state_d = WR_ADDR;
        else if (req_read_i && !req_invalidate_i)  state_d = RD_ADDR;
      end
      RD_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        m_rready = 1'b1;
        if (m_rvalid && m_rlast) state_d = RD_DONE;
      end
      RD_DONE: begin
        rd_valid_o = !drop_q && !req_invalidate_i;
        state_d    = IDLE;
      end
      WR_ADDR: begin
        // AW and W are offered together; W may run ahead of AW.
        m_awvalid = 1'b1;
        m_wvalid  = !w_done_q;
        if (m_awready) state_d = WR_DATA;
      end
      WR_DATA: begin
        m_wvalid = !w_done_q;
        if (w_done_q || (w_hs && w_last)) state_d = WR_RESP;
      end
      WR_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_o <= '0;
      drop_q    <= 1'b0;
      w_done_q  <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        w_done_q <= 1'b0;
        if (req_write_i) begin
          addr_q  <= req_address_i;
          wdata_q <= wr_data_i;
        end else if (req_read_i && !req_invalidate_i) begin
          addr_q <= req_address_i;
          drop_q <= 1'b0;
        end
      end
      if (rd_state && req_invalidate_i) drop_q <= 1'b1;
      if (r_hs) begin
        // A discarded burst is still drained but never lands in rd_data_o.
        if (!drop_q && !req_invalidate_i)
          for (int i = 0; i < int'(BURST_WORDS); i++)
            if (r_cnt == 4'(i)) rd_data_o[i] <= m_rdata;
        // RLAST is trusted for termination; a misplaced one is flagged.
        if ((axi_resp_t'(m_rresp) != OKAY) || (m_rlast != r_last)) err_o <= 1'b1;
      end
      if (w_hs && w_last) w_done_q <= 1'b1;
      if (m_bvalid && m_bready && (axi_resp_t'(m_bresp) != OKAY)) err_o <= 1'b1;
    end
  end

endmodule
